// File: rtl/voxel_gpu_pkg.sv
// Shared definitions for the voxel GPU frame sequencer: register map,
// CONTROL/STATUS bit positions and the sequencer state encoding.
package voxel_gpu_pkg;

    localparam logic [7:0] REG_FRONT   = 8'd0;
    localparam logic [7:0] REG_BACK    = 8'd1;
    localparam logic [7:0] REG_COLOUR  = 8'd2;
    localparam logic [7:0] REG_CONTROL = 8'd3;
    localparam logic [7:0] REG_STATUS  = 8'd4;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_SWAP_EN = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned CTRL_ABORT   = 3;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        FINISH = 2'd2
    } seq_state_t;

endpackage

// File: rtl/clear_addr_gen.sv
// Pixel-pair walker for the buffer clear: steps x by two pixels per accepted
// write, wraps into the next row, and reports the byte offset into the buffer.
module clear_addr_gen
    import voxel_gpu_pkg::*;
#(
    parameter int unsigned WIDTH   = 320,
    parameter int unsigned HEIGHT  = 240,
    parameter int unsigned Y_SHIFT = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        advance,
    output logic        last,
    output logic [31:0] offset
);

    localparam logic [31:0] X_LAST = 32'(WIDTH - 2);
    localparam logic [31:0] Y_LAST = 32'(HEIGHT - 1);

    logic [31:0] x;
    logic [31:0] y;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= y + 32'd1;
            end else begin
                x <= x + 32'd2;
            end
        end
    end

    assign last   = (x == X_LAST) && (y == Y_LAST);
    assign offset = (y << Y_SHIFT) + (x << 1);

endmodule

// File: rtl/voxel_frame_sequencer.sv
// Double-buffer frame controller: clears the back buffer to a solid colour over
// an Avalon-MM write master, optionally swaps front/back, and raises an interrupt.
module voxel_frame_sequencer
    import voxel_gpu_pkg::*;
#(
    parameter logic [31:0] DEFAULT_BUFFER      = 32'h0800_0000,
    parameter logic [31:0] DEFAULT_BACK_BUFFER = 32'h0800_0000,
    parameter int unsigned WIDTH               = 320,
    parameter int unsigned HEIGHT              = 240,
    parameter int unsigned Y_SHIFT             = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  s1_address,
    output logic [31:0] s1_readdata,
    input  logic [31:0] s1_writedata,
    input  logic        s1_write,
    input  logic        s1_read,
    output logic        s1_waitrequest,
    output logic        irq,
    output logic [31:0] m1_address,
    output logic [31:0] m1_writedata,
    output logic        m1_write,
    input  logic        m1_waitrequest
);

    seq_state_t  state;
    logic [31:0] front;
    logic [31:0] back;
    logic [15:0] colour;
    logic [15:0] fill_colour;
    logic        swap_en;
    logic        irq_en;
    logic        done;
    logic        abort_pending;

    logic        busy;
    logic        ctrl_write;
    logic        start;
    logic        abort_req;
    logic        accept;
    logic        last;
    logic [31:0] offset;
    logic        unused_inputs;

    assign unused_inputs = s1_read;

    assign busy       = (state != IDLE);
    assign ctrl_write = s1_write && (s1_address == REG_CONTROL);
    assign start      = ctrl_write && s1_writedata[CTRL_START] && (state == IDLE);
    assign abort_req  = ctrl_write && s1_writedata[CTRL_ABORT] && (state == CLEAR);
    assign accept     = (state == CLEAR) && !m1_waitrequest;

    clear_addr_gen #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .Y_SHIFT (Y_SHIFT)
    ) u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .clear   (start),
        .advance (accept),
        .last    (last),
        .offset  (offset)
    );

    // An abort that lands on a stalled write is remembered so the write
    // completes under Avalon hold rules before returning to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            abort_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    abort_pending <= 1'b0;
                    if (start) state <= CLEAR;
                end
                CLEAR: begin
                    if (accept) begin
                        abort_pending <= 1'b0;
                        if (abort_req || abort_pending) state <= IDLE;
                        else if (last)                  state <= FINISH;
                    end else if (abort_req) begin
                        abort_pending <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            front       <= DEFAULT_BUFFER;
            back        <= DEFAULT_BACK_BUFFER;
            colour      <= '0;
            fill_colour <= '0;
            swap_en     <= 1'b0;
            irq_en      <= 1'b0;
        end else begin
            if (s1_write && !busy) begin
                case (s1_address)
                    REG_FRONT:  front  <= s1_writedata;
                    REG_BACK:   back   <= s1_writedata;
                    REG_COLOUR: colour <= s1_writedata[15:0];
                    default:    ;
                endcase
            end
            if (start) begin
                swap_en     <= s1_writedata[CTRL_SWAP_EN];
                irq_en      <= s1_writedata[CTRL_IRQ_EN];
                fill_colour <= colour;
            end
            if ((state == FINISH) && swap_en) begin
                front <= back;
                back  <= front;
            end
        end
    end

    // Later assignments take priority: FINISH setting DONE beats a clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            if (s1_write && (s1_address == REG_STATUS) && s1_writedata[STAT_DONE]) done <= 1'b0;
            if (start)             done <= 1'b0;
            if (state == FINISH)   done <= 1'b1;
        end
    end

    always_comb begin
        s1_readdata = '0;
        case (s1_address)
            REG_FRONT:   s1_readdata = front;
            REG_BACK:    s1_readdata = back;
            REG_COLOUR:  s1_readdata = {16'b0, colour};
            REG_CONTROL: s1_readdata = {29'b0, irq_en, swap_en, 1'b0};
            REG_STATUS:  s1_readdata = {30'b0, done, busy};
            default:     s1_readdata = '0;
        endcase
    end

    assign s1_waitrequest = 1'b0;
    assign irq            = done && irq_en;
    assign m1_write       = (state == CLEAR);
    assign m1_address     = back + offset;
    assign m1_writedata   = {fill_colour, fill_colour};

endmodule

// File: tb/tb_voxel_frame_sequencer.sv
// Directed bench for voxel_frame_sequencer with a scoreboard of expected
// master writes and a monitor that enforces Avalon hold-while-stalled.
module tb_voxel_frame_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned YS = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s1_address = '0;
    logic [31:0] s1_readdata;
    logic [31:0] s1_writedata = '0;
    logic        s1_write = 1'b0;
    logic        s1_read = 1'b0;
    logic        s1_waitrequest;
    logic        irq;
    logic [31:0] m1_address;
    logic [31:0] m1_writedata;
    logic        m1_write;
    logic        m1_waitrequest = 1'b0;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned accepted = 0;
    logic        rand_wait = 1'b0;
    logic [63:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    voxel_frame_sequencer #(
        .DEFAULT_BUFFER      (32'h0800_0000),
        .DEFAULT_BACK_BUFFER (32'h0800_0000),
        .WIDTH               (W),
        .HEIGHT              (H),
        .Y_SHIFT             (YS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .s1_address     (s1_address),
        .s1_readdata    (s1_readdata),
        .s1_writedata   (s1_writedata),
        .s1_write       (s1_write),
        .s1_read        (s1_read),
        .s1_waitrequest (s1_waitrequest),
        .irq            (irq),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_write       (m1_write),
        .m1_waitrequest (m1_waitrequest)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
        s1_address   = addr;
        s1_writedata = data;
        s1_write     = 1'b1;
        tick();
        s1_write     = 1'b0;
    endtask

    task automatic reg_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        s1_address = addr;
        s1_read    = 1'b1;
        #1;
        chk(tag, s1_readdata, exp);
        s1_read    = 1'b0;
    endtask

    task automatic push_frame(input logic [31:0] base, input logic [15:0] c);
        for (int y = 0; y < int'(H); y++)
            for (int x = 0; x < int'(W); x += 2)
                exp_q.push_back({base + (32'(y) << YS) + 32'(x * 2), c, c});
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st;
        st = '0;
        for (int i = 0; i < 200; i++) begin
            s1_address = 8'd4;
            #1;
            st = s1_readdata;
            if (st[1]) break;
            tick();
        end
        chk(tag, {31'b0, st[1]}, 32'd1);
    endtask

    // Scoreboard and stall-hold monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_write_held", {31'b0, m1_write}, 32'd1);
                chk("stall_addr_held", m1_address, prev_addr);
                chk("stall_data_held", m1_writedata, prev_data);
            end
            if (m1_write && !m1_waitrequest) begin
                logic [63:0] e;
                accepted++;
                chk("write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("m1_address", m1_address, e[63:32]);
                    chk("m1_writedata", m1_writedata, e[31:0]);
                end
            end
            prev_stall = m1_write && m1_waitrequest;
            prev_addr  = m1_address;
            prev_data  = m1_writedata;
        end
    end

    always @(posedge clock) begin
        if (rand_wait) begin
            #1;
            if (rand_wait) m1_waitrequest = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        // Reset state
        #12;
        reset = 1'b0;
        tick();
        reg_check("rst_front", 8'd0, 32'h0800_0000);
        reg_check("rst_back", 8'd1, 32'h0800_0000);
        reg_check("rst_colour", 8'd2, 32'h0);
        reg_check("rst_control", 8'd3, 32'h0);
        reg_check("rst_status", 8'd4, 32'h0);
        reg_check("unmapped", 8'd9, 32'h0);
        chk("rst_m1_write", {31'b0, m1_write}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("s1_waitrequest", {31'b0, s1_waitrequest}, 32'd0);

        // Basic clear with swap and irq, zero waitrequest, latency check
        reg_write(8'd1, 32'h0000_1000);
        reg_write(8'd2, 32'hABCD_F800);
        reg_check("colour_upper_zero", 8'd2, 32'h0000_F800);
        push_frame(32'h0000_1000, 16'hF800);
        reg_write(8'd3, 32'h7);
        repeat (4) tick();
        chk("irq_not_early", {31'b0, irq}, 32'd0);
        tick();
        chk("irq_latency", {31'b0, irq}, 32'd1);
        reg_check("swap_front", 8'd0, 32'h0000_1000);
        reg_check("swap_back", 8'd1, 32'h0800_0000);
        reg_check("status_done", 8'd4, 32'h2);
        reg_check("control_rb", 8'd3, 32'h6);
        chk("frame1_count", accepted, 32'd4);
        chk("frame1_queue_empty", exp_q.size(), 32'd0);

        // DONE clear
        reg_write(8'd4, 32'h2);
        reg_check("done_cleared", 8'd4, 32'h0);
        chk("irq_cleared", {31'b0, irq}, 32'd0);

        // Random stalls, no swap; START and BACK writes while busy are ignored
        reg_write(8'd1, 32'h0000_2000);
        reg_write(8'd2, 32'h0000_001F);
        push_frame(32'h0000_2000, 16'h001F);
        rand_wait = 1'b1;
        reg_write(8'd3, 32'h1);
        reg_write(8'd1, 32'h0000_3000);
        reg_write(8'd3, 32'h1);
        reg_check("busy_status", 8'd4, 32'h1);
        reg_check("back_frozen", 8'd1, 32'h0000_2000);
        wait_done("frame2_done");
        rand_wait = 1'b0;
        tick();
        m1_waitrequest = 1'b0;
        repeat (20) tick();
        chk("frame2_count", accepted, 32'd8);
        chk("frame2_queue_empty", exp_q.size(), 32'd0);
        reg_check("noswap_front", 8'd0, 32'h0000_1000);
        reg_check("noswap_back", 8'd1, 32'h0000_2000);
        chk("irq_disabled", {31'b0, irq}, 32'd0);

        // ABORT during a stalled write
        m1_waitrequest = 1'b1;
        exp_q.push_back({32'h0000_2000, 32'h001F_001F});
        reg_write(8'd3, 32'h7);
        reg_write(8'd3, 32'h8);
        repeat (3) tick();
        chk("abort_write_held", {31'b0, m1_write}, 32'd1);
        reg_check("abort_still_busy", 8'd4, 32'h1);
        m1_waitrequest = 1'b0;
        tick();
        chk("abort_m1_write_low", {31'b0, m1_write}, 32'd0);
        reg_check("abort_status", 8'd4, 32'h0);
        repeat (4) tick();
        chk("abort_count", accepted, 32'd9);
        reg_check("abort_noswap_front", 8'd0, 32'h0000_1000);
        reg_check("abort_noswap_back", 8'd1, 32'h0000_2000);
        chk("abort_irq", {31'b0, irq}, 32'd0);

        // ABORT in IDLE is ignored
        reg_write(8'd3, 32'h8);
        tick();
        reg_check("idle_abort_status", 8'd4, 32'h0);
        chk("idle_abort_m1", {31'b0, m1_write}, 32'd0);

        // Asynchronous reset mid-clear
        m1_waitrequest = 1'b1;
        reg_write(8'd3, 32'h1);
        tick();
        chk("pre_reset_m1_write", {31'b0, m1_write}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_m1_write", {31'b0, m1_write}, 32'd0);
        reg_check("async_reset_front", 8'd0, 32'h0800_0000);
        reg_check("async_reset_status", 8'd4, 32'h0);
        tick();
        reset = 1'b0;
        m1_waitrequest = 1'b0;
        repeat (3) tick();
        chk("post_reset_count", accepted, 32'd9);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
